// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode. It takes up to IN_WIDTH lanes per cycle and
// offers the OUT_WIDTH oldest entries. It supports a full flush and a flush that keeps the delay slot.

module inst_fetch_queue_chk #(
    parameter int DEPTH     = 8,
    parameter int OUT_WIDTH = 2,
    parameter int CNT_W     = 4,
    parameter int POP_W     = 2
) (
    input logic             clk,
    input logic             reset,
    input logic [POP_W-1:0] out_pop,
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] count_nxt
);
    // Decode may only consume entries that are present and offered; occupancy stays bounded
    pop_legal: assert property (@(posedge clk) disable iff (reset)
        (CNT_W'(out_pop) <= count) && (CNT_W'(out_pop) <= CNT_W'(OUT_WIDTH)));
    cnt_bound: assert property (@(posedge clk) disable iff (reset)
        count_nxt <= CNT_W'(DEPTH));
endmodule

module inst_fetch_queue #(
    parameter int  DEPTH     = 8,
    parameter int  IN_WIDTH  = 2,
    parameter int  OUT_WIDTH = 2,
    parameter int  ENTRY_W   = 66,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1,
    localparam int POP_W     = $clog2(OUT_WIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          flush_keep_ds,
    input  logic [IN_WIDTH-1:0]           in_valid,
    input  logic [IN_WIDTH*ENTRY_W-1:0]   in_data,
    output logic                          in_ready,
    output logic [OUT_WIDTH-1:0]          out_valid,
    output logic [OUT_WIDTH*ENTRY_W-1:0]  out_data,
    input  logic [POP_W-1:0]              out_pop,
    output logic [CNT_W-1:0]              count,
    output logic                          ds_wait
);
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r, tail_r, head_nxt_s, tail_nxt_s, head_pop_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s, push_req_s, push_n_s, pop_s, rem_s, wr_n_s;
    logic               ds_wait_r, ds_nxt_s;

    function automatic logic [CNT_W-1:0] lane_popcount(input logic [IN_WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int i = 0; i < IN_WIDTH; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    assign in_ready = !reset && ((CNT_W'(DEPTH) - count_r) >= CNT_W'(IN_WIDTH));
    assign count    = count_r;
    assign ds_wait  = ds_wait_r;

    // Next-state selection: flush beats flush_keep_ds, which beats the normal push/pop update
    always_comb begin
        push_req_s  = in_ready ? lane_popcount(in_valid) : {CNT_W{1'b0}};
        push_n_s    = (ds_wait_r && (push_req_s > CNT_W'(1'b1))) ? CNT_W'(1'b1) : push_req_s;
        pop_s       = CNT_W'(out_pop);
        rem_s       = count_r - pop_s;
        head_pop_s  = head_r + PTR_W'(out_pop);
        head_nxt_s  = head_pop_s;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        ds_nxt_s    = ds_wait_r;
        wr_n_s      = {CNT_W{1'b0}};
        if (flush) begin
            head_nxt_s  = {PTR_W{1'b0}};
            tail_nxt_s  = {PTR_W{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
            ds_nxt_s    = 1'b0;
        end else if (flush_keep_ds) begin
            if (rem_s != {CNT_W{1'b0}}) begin
                tail_nxt_s  = head_pop_s + PTR_W'(1'b1);
                count_nxt_s = CNT_W'(1'b1);
                ds_nxt_s    = 1'b0;
            end else if (push_n_s != {CNT_W{1'b0}}) begin
                // Queue drains to empty: the delay slot arrives on lane 0 this very cycle
                wr_n_s      = CNT_W'(1'b1);
                tail_nxt_s  = tail_r + PTR_W'(1'b1);
                count_nxt_s = CNT_W'(1'b1);
                ds_nxt_s    = 1'b0;
            end else begin
                count_nxt_s = {CNT_W{1'b0}};
                ds_nxt_s    = 1'b1;
            end
        end else begin
            wr_n_s      = push_n_s;
            tail_nxt_s  = tail_r + PTR_W'(push_n_s);
            count_nxt_s = count_r + push_n_s - pop_s;
            ds_nxt_s    = (push_n_s != {CNT_W{1'b0}}) ? 1'b0 : ds_wait_r;
        end
    end

    // Pointer, occupancy and delay-slot state
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r    <= {PTR_W{1'b0}};
            tail_r    <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            ds_wait_r <= 1'b0;
        end else begin
            head_r    <= head_nxt_s;
            tail_r    <= tail_nxt_s;
            count_r   <= count_nxt_s;
            ds_wait_r <= ds_nxt_s;
        end
    end

    // Payload write; only accepted lanes land in the array
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (!reset && (CNT_W'(i) < wr_n_s)) begin
                mem_r[tail_r + PTR_W'(i)] <= in_data[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Oldest entries presented to decode
    always_comb begin
        out_valid = {OUT_WIDTH{1'b0}};
        out_data  = {(OUT_WIDTH*ENTRY_W){1'b0}};
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_valid[i]                    = CNT_W'(i) < count_r;
            out_data[i*ENTRY_W +: ENTRY_W]  = mem_r[head_r + PTR_W'(i)];
        end
    end

    inst_fetch_queue_chk #(
        .DEPTH(DEPTH), .OUT_WIDTH(OUT_WIDTH), .CNT_W(CNT_W), .POP_W(POP_W)
    ) u_chk (
        .clk(clk), .reset(reset), .out_pop(out_pop), .count(count_r), .count_nxt(count_nxt_s)
    );
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised instruction queue between fetch_stage and decode_stage. It decouples I-side fetch bandwidth from decode issue width.
- Accepts up to IN_WIDTH fetched instructions per cycle and presents up to OUT_WIDTH oldest entries to decode.
- Supports a full flush (exception/ERET/TLB op) and a delay-slot-preserving flush (BPU misprediction), which the current single-entry IF/ID handoff cannot express.
- First building block toward a multi-issue front end.

Parameters:
- DEPTH, 8: queue entries; power of two, >= 2*IN_WIDTH.
- IN_WIDTH, 2: fetch lanes per cycle.
- OUT_WIDTH, 2: decode lanes per cycle.
- ENTRY_W, 66: payload bits per entry ({fetch_ex, predict_taken, pc[31:0], inst[31:0]}); opaque to the queue.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  full flush: discard all entries
- flush_keep_ds  in  1  BPU flush: keep only the delay slot
- in_valid  in  IN_WIDTH  per-lane push valid; contiguous from lane 0
- in_data  in  IN_WIDTH*ENTRY_W  lane i at bits [i*ENTRY_W +: ENTRY_W]; lane 0 is oldest
- in_ready  out  1  all IN_WIDTH lanes can be accepted this cycle
- out_valid  out  OUT_WIDTH  out_valid[i] = entry head+i present
- out_data  out  OUT_WIDTH*ENTRY_W  entry head+i on lane i
- out_pop  in  $clog2(OUT_WIDTH+1)  number of entries decode consumes this cycle
- count  out  $clog2(DEPTH)+1  current occupancy
- ds_wait  out  1  delay slot outstanding; next push keeps lane 0 only

Behaviour:
- State: circular array mem[DEPTH]; head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register; ds_wait register.
- Reset (sync, clk edge with reset=1): head=tail=0, count=0, ds_wait=0. Outputs: out_valid=0, count=0, ds_wait=0, in_ready=0 while reset is high. Mem contents are don't-care.
- in_ready = !reset && (DEPTH - count >= IN_WIDTH). It depends only on registered count, so there is no combinational path from out_pop to in_ready.
- Push: push_n = popcount(in_valid) when in_ready, else 0. Lane i is written to mem[tail+i]; tail advances by push_n.
  - When ds_wait=1, push_n is clamped to min(push_n, 1) and ds_wait clears on any nonzero push.
- Pop: out_valid[i] = (i < count); out_data lanes are combinational reads of mem[head+i].
  - out_pop <= popcount(out_valid) is required. Violation is an assertion failure; RTL behaviour is undefined.
  - head advances by out_pop.
- Normal update: count_next = count + push_n - out_pop. Simultaneous push and pop are legal at any occupancy, including full (count=DEPTH, in_ready=0, pop still allowed) and empty (no pop).
- Same-cycle push is never visible on out_valid (1-cycle latency, no bypass).
- flush (highest priority): head=tail=0, count=0, ds_wait=0. Same-cycle push and pop are discarded (pop still dequeues from decode's view).
- flush_keep_ds (only when flush=0):
  - Let rem = count - out_pop, the entries left after this cycle's pop.
  - rem >= 1: keep only the oldest remaining entry. head = head + out_pop; tail = head_new + 1; count = 1; same-cycle push is discarded; ds_wait = 0.
  - rem = 0 and in_valid[0] && in_ready: write lane 0 only. count = 1; ds_wait = 0.
  - rem = 0 and no push: count = 0; ds_wait = 1.
- flush_keep_ds while ds_wait=1 and the queue is empty: ds_wait stays 1.
- Reset mid-operation overrides everything, including flush and an outstanding ds_wait.
- Pointer and count arithmetic is in widths sized above. Count never exceeds DEPTH; assert on overflow/underflow.

Test Plan:
- Defaults. After reset: push 2 lanes/cycle for 4 cycles with out_pop=0 -> count = 2,4,6,8; in_ready drops to 0 at count=8; a 5th push is ignored; out_data lanes 0/1 hold the first two pushed entries.
- Full queue (count=8): out_pop=2 and in_valid=2'b11 in the same cycle -> nothing pushed (in_ready was 0); count=6. Next cycle the push is accepted; count=8; tail wrapped to 0; order preserved across the wrap.
- count=5, head=6: flush with in_valid=2'b11 and out_pop=1 -> next cycle count=0, out_valid=0, head=tail=0, in_ready=1.
- count=4 (entries A,B,C,D): out_pop=1 plus flush_keep_ds -> next cycle count=1 and out_data lane0=B; push in that cycle discarded.
- count=2: out_pop=2 plus flush_keep_ds, no push -> count=0, ds_wait=1. Next push in_valid=2'b11 (X,Y) -> count=1, lane0=X, ds_wait=0.
- Reset asserted with count=6 and ds_wait=1 -> next cycle count=0, ds_wait=0, out_valid=0; in_ready=1 once reset deasserts.
